biriscv_csr_wb_pipe: RTL and testbench

// - Carries CSR-unit E1 results (read value, write data, early exception) through E2 to writeback.
// - Merges late LSU faults (E2) and interrupt injection (E2->WB), and drives the CSR regfile's
//   csr_writeback_* bus, rd writeback and pipeline squash.
// - Sits directly downstream of the CSR issue/E1 stage; its WB outputs feed that stage's writeback inputs.

---
 rtl/biriscv_csr_wb_pipe.sv | 162 ++++++++++++++++
 tb/tb_biriscv_csr_wb_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_csr_wb_pipe.sv
// biriscv_csr_wb_pipe
// Carries CSR-unit E1 results through E2 into writeback, merging late LSU
// faults and interrupt injection, and drives the CSR regfile writeback bus,
// the integer register writeback and the pipeline squash request.
module biriscv_csr_wb_pipe #(
   parameter int SUPPORT_MEM_FAULT = 1,
   parameter int SUPPORT_INTERRUPT = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        e1_valid_i,
   input  logic [31:0] e1_pc_i,
   input  logic [31:0] e1_opcode_i,
   input  logic [4:0]  e1_rd_idx_i,
   input  logic [31:0] e1_value_i,
   input  logic        e1_write_i,
   input  logic [31:0] e1_wdata_i,
   input  logic [5:0]  e1_exception_i,
   input  logic [5:0]  mem_exception_i,
   input  logic [31:0] mem_addr_i,
   input  logic        take_interrupt_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        csr_writeback_write_o,
   output logic [11:0] csr_writeback_waddr_o,
   output logic [31:0] csr_writeback_wdata_o,
   output logic [5:0]  csr_writeback_exception_o,
   output logic [31:0] csr_writeback_exception_pc_o,
   output logic [31:0] csr_writeback_exception_addr_o,
   output logic        wb_rd_write_o,
   output logic [4:0]  wb_rd_idx_o,
   output logic [31:0] wb_rd_value_o,
   output logic        squash_o
);

   localparam logic [5:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
   localparam logic [5:0] EXCEPTION_INTERRUPT           = 6'h20;

   // E2 stage registers
   logic        r_e2_valid;
   logic [31:0] r_e2_pc;
   logic [11:0] r_e2_csr_addr;
   logic [4:0]  r_e2_rd_idx;
   logic [31:0] r_e2_value;
   logic        r_e2_write;
   logic [31:0] r_e2_wdata;
   logic [5:0]  r_e2_exception;

   // WB stage registers
   logic        r_wb_valid;
   logic [31:0] r_wb_pc;
   logic [11:0] r_wb_csr_addr;
   logic [4:0]  r_wb_rd_idx;
   logic [31:0] r_wb_value;
   logic        r_wb_write;
   logic [31:0] r_wb_wdata;
   logic [5:0]  r_wb_exception;
   logic [31:0] r_wb_exc_addr;

   logic [5:0]  w_mem_exception;
   logic        w_interrupt;
   logic [5:0]  w_merge_exception;
   logic [31:0] w_merge_addr;
   logic        w_wb_load;
   logic        w_csr_write;
   logic        w_rd_write;
   logic        w_unused_opcode;

   // Only the CSR address field of the opcode is carried downstream.
   assign w_unused_opcode = ^e1_opcode_i[19:0];

   assign w_mem_exception = (SUPPORT_MEM_FAULT != 0) ? mem_exception_i : 6'd0;
   assign w_interrupt     = (SUPPORT_INTERRUPT != 0) & take_interrupt_i;
   assign squash_o        = r_wb_valid & (r_wb_exception != 6'd0);
   assign w_wb_load       = r_e2_valid & ~stall_i & ~squash_o;

   // Pick the final exception for the entry leaving E2: early E1 cause first,
   // then a late LSU fault, then an injected interrupt.
   always_comb begin
      w_merge_exception = 6'd0;
      w_merge_addr      = 32'd0;
      if (r_e2_exception != 6'd0) begin
         w_merge_exception = r_e2_exception;
         if (r_e2_exception == EXCEPTION_ILLEGAL_INSTRUCTION)
            w_merge_addr = r_e2_value;
      end else if (w_mem_exception != 6'd0) begin
         w_merge_exception = w_mem_exception;
         w_merge_addr      = mem_addr_i;
      end else if (w_interrupt) begin
         w_merge_exception = EXCEPTION_INTERRUPT;
      end
   end

   // E2 capture: squash or flush empties it, otherwise it follows E1 unless stalled.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_e2_valid     <= 1'b0;
         r_e2_pc        <= 32'd0;
         r_e2_csr_addr  <= 12'd0;
         r_e2_rd_idx    <= 5'd0;
         r_e2_value     <= 32'd0;
         r_e2_write     <= 1'b0;
         r_e2_wdata     <= 32'd0;
         r_e2_exception <= 6'd0;
      end else if (squash_o | flush_i) begin
         r_e2_valid     <= 1'b0;
         r_e2_exception <= 6'd0;
      end else if (~stall_i) begin
         r_e2_valid     <= e1_valid_i;
         r_e2_pc        <= e1_pc_i;
         r_e2_csr_addr  <= e1_opcode_i[31:20];
         r_e2_rd_idx    <= e1_rd_idx_i;
         r_e2_value     <= e1_value_i;
         r_e2_write     <= e1_write_i;
         r_e2_wdata     <= e1_wdata_i;
         r_e2_exception <= e1_exception_i;
      end
   end

   // WB holds an entry for exactly one cycle; anything else loads a bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wb_valid     <= 1'b0;
         r_wb_pc        <= 32'd0;
         r_wb_csr_addr  <= 12'd0;
         r_wb_rd_idx    <= 5'd0;
         r_wb_value     <= 32'd0;
         r_wb_write     <= 1'b0;
         r_wb_wdata     <= 32'd0;
         r_wb_exception <= 6'd0;
         r_wb_exc_addr  <= 32'd0;
      end else if (w_wb_load) begin
         r_wb_valid     <= 1'b1;
         r_wb_pc        <= r_e2_pc;
         r_wb_csr_addr  <= r_e2_csr_addr;
         r_wb_rd_idx    <= r_e2_rd_idx;
         r_wb_value     <= r_e2_value;
         r_wb_write     <= r_e2_write;
         r_wb_wdata     <= r_e2_wdata;
         r_wb_exception <= w_merge_exception;
         r_wb_exc_addr  <= w_merge_addr;
      end else begin
         r_wb_valid     <= 1'b0;
         r_wb_write     <= 1'b0;
         r_wb_exception <= 6'd0;
      end
   end

   assign w_csr_write = r_wb_valid & r_wb_write & (r_wb_exception == 6'd0);
   assign w_rd_write  = w_csr_write & (r_wb_rd_idx != 5'd0);

   assign csr_writeback_write_o          = w_csr_write;
   assign csr_writeback_waddr_o          = w_csr_write ? r_wb_csr_addr : 12'd0;
   assign csr_writeback_wdata_o          = w_csr_write ? r_wb_wdata    : 32'd0;
   assign csr_writeback_exception_o      = r_wb_valid  ? r_wb_exception : 6'd0;
   assign csr_writeback_exception_pc_o   = squash_o    ? r_wb_pc       : 32'd0;
   assign csr_writeback_exception_addr_o = squash_o    ? r_wb_exc_addr : 32'd0;
   assign wb_rd_write_o                  = w_rd_write;
   assign wb_rd_idx_o                    = w_rd_write ? r_wb_rd_idx : 5'd0;
   assign wb_rd_value_o                  = w_rd_write ? r_wb_value  : 32'd0;

endmodule

// File: tb/tb_biriscv_csr_wb_pipe.sv
// tb_biriscv_csr_wb_pipe
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference of the CSR writeback pipe.
module tb_biriscv_csr_wb_pipe;

   localparam logic [5:0] EXC_ILLEGAL   = 6'h12;
   localparam logic [5:0] EXC_FAULT_LD  = 6'h15;
   localparam logic [5:0] EXC_ECALL     = 6'h18;
   localparam logic [5:0] EXC_INTERRUPT = 6'h20;
   localparam logic [5:0] EXC_ERET      = 6'h30;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] opcode;
      logic [4:0]  rd;
      logic [31:0] value;
      logic        write;
      logic [31:0] wdata;
      logic [5:0]  exc;
      logic [31:0] addr;
   } entry_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        e1_valid_i = 1'b0;
   logic [31:0] e1_pc_i = '0;
   logic [31:0] e1_opcode_i = '0;
   logic [4:0]  e1_rd_idx_i = '0;
   logic [31:0] e1_value_i = '0;
   logic        e1_write_i = 1'b0;
   logic [31:0] e1_wdata_i = '0;
   logic [5:0]  e1_exception_i = '0;
   logic [5:0]  mem_exception_i = '0;
   logic [31:0] mem_addr_i = '0;
   logic        take_interrupt_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        csr_writeback_write_o;
   logic [11:0] csr_writeback_waddr_o;
   logic [31:0] csr_writeback_wdata_o;
   logic [5:0]  csr_writeback_exception_o;
   logic [31:0] csr_writeback_exception_pc_o;
   logic [31:0] csr_writeback_exception_addr_o;
   logic        wb_rd_write_o;
   logic [4:0]  wb_rd_idx_o;
   logic [31:0] wb_rd_value_o;
   logic        squash_o;

   int checkCount = 0;
   int passCount  = 0;
   int writePulses;

   entry_t modelE2;
   entry_t modelWb;

   biriscv_csr_wb_pipe dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .e1_valid_i(e1_valid_i), .e1_pc_i(e1_pc_i), .e1_opcode_i(e1_opcode_i),
      .e1_rd_idx_i(e1_rd_idx_i), .e1_value_i(e1_value_i), .e1_write_i(e1_write_i),
      .e1_wdata_i(e1_wdata_i), .e1_exception_i(e1_exception_i),
      .mem_exception_i(mem_exception_i), .mem_addr_i(mem_addr_i),
      .take_interrupt_i(take_interrupt_i), .stall_i(stall_i), .flush_i(flush_i),
      .csr_writeback_write_o(csr_writeback_write_o),
      .csr_writeback_waddr_o(csr_writeback_waddr_o),
      .csr_writeback_wdata_o(csr_writeback_wdata_o),
      .csr_writeback_exception_o(csr_writeback_exception_o),
      .csr_writeback_exception_pc_o(csr_writeback_exception_pc_o),
      .csr_writeback_exception_addr_o(csr_writeback_exception_addr_o),
      .wb_rd_write_o(wb_rd_write_o), .wb_rd_idx_o(wb_rd_idx_o),
      .wb_rd_value_o(wb_rd_value_o), .squash_o(squash_o)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // Single point of comparison for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
   endtask

   // Compare all outputs against what the reference WB entry implies
   task automatic checkAll();
      logic commits;
      logic faults;
      commits = modelWb.valid && modelWb.write && (modelWb.exc == 6'd0);
      faults  = modelWb.valid && (modelWb.exc != 6'd0);
      checkOutput("write",   32'(csr_writeback_write_o), 32'(commits));
      checkOutput("waddr",   32'(csr_writeback_waddr_o), commits ? 32'(modelWb.opcode[31:20]) : 32'd0);
      checkOutput("wdata",   csr_writeback_wdata_o, commits ? modelWb.wdata : 32'd0);
      checkOutput("exc",     32'(csr_writeback_exception_o), faults ? 32'(modelWb.exc) : 32'd0);
      checkOutput("exc_pc",  csr_writeback_exception_pc_o, faults ? modelWb.pc : 32'd0);
      checkOutput("exc_addr",csr_writeback_exception_addr_o, faults ? modelWb.addr : 32'd0);
      checkOutput("rd_write",32'(wb_rd_write_o), 32'(commits && modelWb.rd != 5'd0));
      checkOutput("rd_idx",  32'(wb_rd_idx_o), (commits && modelWb.rd != 5'd0) ? 32'(modelWb.rd) : 32'd0);
      checkOutput("rd_value",wb_rd_value_o, (commits && modelWb.rd != 5'd0) ? modelWb.value : 32'd0);
      checkOutput("squash",  32'(squash_o), 32'(faults));
   endtask

   // Advance one clock: the reference consumes the inputs seen at the edge,
   // then outputs are compared 1ns later.
   task automatic tick();
      entry_t nextE2;
      entry_t nextWb;
      logic   squashNow;
      @(posedge clk_i);
      squashNow = modelWb.valid && (modelWb.exc != 6'd0);
      nextWb = '0;
      if (modelE2.valid && !stall_i && !squashNow) begin
         nextWb = modelE2;
         if (modelE2.exc != 6'd0) begin
            nextWb.addr = (modelE2.exc == EXC_ILLEGAL) ? modelE2.value : 32'd0;
         end else if (mem_exception_i != 6'd0) begin
            nextWb.exc  = mem_exception_i;
            nextWb.addr = mem_addr_i;
         end else if (take_interrupt_i) begin
            nextWb.exc  = EXC_INTERRUPT;
            nextWb.addr = 32'd0;
         end
      end
      if (squashNow || flush_i) nextE2 = '0;
      else if (stall_i) nextE2 = modelE2;
      else begin
         nextE2 = '0;
         nextE2.valid  = e1_valid_i;
         nextE2.pc     = e1_pc_i;
         nextE2.opcode = e1_opcode_i;
         nextE2.rd     = e1_rd_idx_i;
         nextE2.value  = e1_value_i;
         nextE2.write  = e1_write_i;
         nextE2.wdata  = e1_wdata_i;
         nextE2.exc    = e1_exception_i;
      end
      modelE2 = nextE2;
      modelWb = nextWb;
      #1;
      checkAll();
      if (csr_writeback_write_o) writePulses++;
   endtask

   // Present one instruction (or bubble) in E1 plus the side-band inputs
   task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] opcode,
                                input logic [4:0] rd, input logic [31:0] value, input logic write,
                                input logic [31:0] wdata, input logic [5:0] exc,
                                input logic [5:0] memExc, input logic [31:0] memAddr,
                                input logic irq, input logic stall, input logic flush);
      e1_valid_i = valid;  e1_pc_i = pc;  e1_opcode_i = opcode;  e1_rd_idx_i = rd;
      e1_value_i = value;  e1_write_i = write;  e1_wdata_i = wdata;  e1_exception_i = exc;
      mem_exception_i = memExc;  mem_addr_i = memAddr;  take_interrupt_i = irq;
      stall_i = stall;  flush_i = flush;
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      modelE2 = '0;
      modelWb = '0;
      writePulses = 0;
      #12;
      checkAll();
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      // CSRRW x0, mscratch, x5
      applyStimulus(1'b1, 32'h80000000, 32'h34029073, 5'd0, 32'd0, 1'b1, 32'hDEADBEEF, 6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick(); idle(); tick();
      checkOutput("csrrw_write", 32'(csr_writeback_write_o), 32'd1);
      checkOutput("csrrw_waddr", 32'(csr_writeback_waddr_o), 32'h340);
      tick();
      checkOutput("csrrw_single", 32'(csr_writeback_write_o), 32'd0);

      // Illegal instruction with a follower that must be squashed
      applyStimulus(1'b1, 32'h80000100, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 1'b0, '0, EXC_ILLEGAL, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h80000104, 32'h30002373, 5'd6, 32'h11111111, 1'b1, 32'h22222222, 6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("ill_addr", csr_writeback_exception_addr_o, 32'hFFFFFFFF);
      checkOutput("ill_squash", 32'(squash_o), 32'd1);
      applyStimulus(1'b1, 32'h80000108, 32'h30002373, 5'd7, 32'h33333333, 1'b1, 32'h44444444, 6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      writePulses = 0;
      repeat (3) tick();
      checkOutput("follower_dropped", 32'(writePulses), 32'd0);

      // Late LSU fault, then the same with an early illegal cause winning
      applyStimulus(1'b1, 32'h80000200, 32'h00002283, 5'd5, 32'h55, 1'b1, 32'h66, 6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, EXC_FAULT_LD, 32'h10000004, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("memflt_exc", 32'(csr_writeback_exception_o), 32'(EXC_FAULT_LD));
      idle(); tick(); tick();
      applyStimulus(1'b1, 32'h80000300, 32'hABCD1234, 5'd5, 32'hABCD1234, 1'b0, '0, EXC_ILLEGAL, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, EXC_FAULT_LD, 32'h10000004, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("prio_exc", 32'(csr_writeback_exception_o), 32'(EXC_ILLEGAL));
      checkOutput("prio_addr", csr_writeback_exception_addr_o, 32'hABCD1234);
      idle(); tick(); tick();

      // CSR write held in E2 by a three-cycle stall
      applyStimulus(1'b1, 32'h80000400, 32'h30529073, 5'd0, 32'd0, 1'b1, 32'h80000200, 6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 6'd0, '0, 1'b0, 1'b1, 1'b0);
      writePulses = 0;
      repeat (3) tick();
      checkOutput("stall_idle", 32'(writePulses), 32'd0);
      idle(); tick();
      checkOutput("stall_waddr", 32'(csr_writeback_waddr_o), 32'h305);
      tick(); tick();
      checkOutput("stall_one_pulse", 32'(writePulses), 32'd1);

      // Interrupt injected on CSRRS t0, mstatus
      applyStimulus(1'b1, 32'h80000040, 32'h300022F3, 5'd5, 32'h00001800, 1'b1, 32'h00001808, 6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, 6'd0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("irq_exc", 32'(csr_writeback_exception_o), 32'(EXC_INTERRUPT));
      checkOutput("irq_pc", csr_writeback_exception_pc_o, 32'h80000040);
      idle(); tick(); tick();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [5:0] exc;
         logic [5:0] memExc;
         case ($urandom_range(0, 9))
            0: exc = EXC_ILLEGAL;
            1: exc = ($urandom_range(0, 1) != 0) ? EXC_ECALL : EXC_ERET;
            default: exc = 6'd0;
         endcase
         memExc = ($urandom_range(0, 9) == 0) ? EXC_FAULT_LD : 6'd0;
         applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 31)),
                       $urandom, $urandom_range(0, 1) != 0, $urandom, exc, memExc, $urandom,
                       $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
         tick();
      end

      // Reset in the middle of a full pipe
      applyStimulus(1'b1, 32'h80000500, 32'h34029073, 5'd4, 32'h77, 1'b1, 32'h88, 6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h80000504, 32'h34129073, 5'd4, 32'h99, 1'b1, 32'hAA, 6'd0, 6'd0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      #2;
      rst_i = 1'b1;
      #1;
      modelE2 = '0;
      modelWb = '0;
      checkAll();
      idle();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      writePulses = 0;
      repeat (3) tick();
      checkOutput("post_reset_quiet", 32'(writePulses), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
